// File: rtl/xm_pkg.sv
// Shared definitions for the execute-stage writeback slice.
package xm_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_AW = 3;

    // Bit positions inside the {V,N,Z,C} status word
    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_V = 3;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StDone  = 2'd2
    } wb_state_e;

    // Per-bit select: take new where mask is set, keep old elsewhere
    function automatic logic [3:0] merge_flags(input logic [3:0] old_f,
                                               input logic [3:0] new_f,
                                               input logic [3:0] mask);
        return (old_f & ~mask) | (new_f & mask);
    endfunction

endpackage

// File: rtl/psw_reg.sv
// Processor status word: masked flag update with full-word load override.
module psw_reg
    import xm_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_upd_en,
    input  logic [3:0] i_mask,
    input  logic [3:0] i_alu_flags,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    output logic [3:0] o_flags
);

    logic [3:0] r_flags;
    logic [3:0] w_flags_d;

    // Next flags: direct load wins over any masked ALU update in the same cycle
    always_comb begin
        w_flags_d = r_flags;
        if (i_upd_en) begin
            w_flags_d = merge_flags(r_flags, i_alu_flags, i_mask);
        end
        if (i_load) begin
            w_flags_d = i_load_val;
        end
    end

    // Flag register with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_flags <= 4'b0000;
        end else begin
            r_flags <= w_flags_d;
        end
    end

    assign o_flags = r_flags;

endmodule

// File: rtl/alu_writeback.sv
// ALU back end: accepts one result per handshake, updates PSW flags and
// writes the result to the register file over a req/ack port.
module alu_writeback
    import xm_pkg::*;
#(
    parameter int unsigned DATA_W = xm_pkg::DATA_W,
    parameter int unsigned REG_AW = xm_pkg::REG_AW
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wb_valid,
    output logic              o_wb_ready,
    input  logic [REG_AW-1:0] i_wb_dst,
    input  logic              i_wb_reg_en,
    input  logic [3:0]        i_wb_flag_mask,
    input  logic              i_byte_op,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic              i_alu_carry,
    input  logic              i_alu_zero,
    input  logic              i_alu_neg,
    input  logic              i_alu_ovf,
    input  logic              i_psw_load,
    input  logic [3:0]        i_psw_in,
    output logic              o_rf_wr_req,
    input  logic              i_rf_wr_ack,
    output logic [REG_AW-1:0] o_rf_wr_addr,
    output logic [DATA_W-1:0] o_rf_wr_data,
    output logic              o_rf_wr_byte,
    output logic [3:0]        o_psw_flags,
    output logic              o_alu_carry_in,
    output logic              o_wb_done
);

    wb_state_e         r_state;
    wb_state_e         w_state_d;
    logic              w_hs;
    logic [REG_AW-1:0] r_dst;
    logic [DATA_W-1:0] r_data;
    logic              r_byte;
    logic [3:0]        w_alu_flags;

    assign w_hs        = i_wb_valid & o_wb_ready;
    assign w_alu_flags = {i_alu_ovf, i_alu_neg, i_alu_zero, i_alu_carry};

    // Next-state: flags-only commands skip the register-file write
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_hs) begin
                    w_state_d = i_wb_reg_en ? StWrite : StDone;
                end
            end
            StWrite: begin
                if (i_rf_wr_ack) begin
                    w_state_d = StDone;
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Holding register keeps the write payload stable while the request is open
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_dst  <= '0;
            r_data <= '0;
            r_byte <= 1'b0;
        end else if (w_hs) begin
            r_dst  <= i_wb_dst;
            r_data <= i_alu_result;
            r_byte <= i_byte_op;
        end
    end

    psw_reg u_psw_reg (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_upd_en    (w_hs),
        .i_mask      (i_wb_flag_mask),
        .i_alu_flags (w_alu_flags),
        .i_load      (i_psw_load),
        .i_load_val  (i_psw_in),
        .o_flags     (o_psw_flags)
    );

    assign o_wb_ready     = (r_state == StIdle);
    assign o_rf_wr_req    = (r_state == StWrite);
    assign o_wb_done      = (r_state == StDone);
    assign o_rf_wr_addr   = r_dst;
    assign o_rf_wr_data   = r_data;
    assign o_rf_wr_byte   = r_byte;
    assign o_alu_carry_in = o_psw_flags[FLAG_C];

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed table, random commands
// against a transaction-level PSW model, reset-mid-write and back-to-back.
module tb_alu_writeback;

    logic        clk;
    logic        rst_n;
    logic        wb_valid;
    logic        wb_ready;
    logic [2:0]  wb_dst;
    logic        wb_reg_en;
    logic [3:0]  wb_flag_mask;
    logic        byte_op;
    logic [15:0] alu_result;
    logic        alu_carry, alu_zero, alu_neg, alu_ovf;
    logic        psw_load;
    logic [3:0]  psw_in;
    logic        rf_wr_req;
    logic        rf_wr_ack;
    logic [2:0]  rf_wr_addr;
    logic [15:0] rf_wr_data;
    logic        rf_wr_byte;
    logic [3:0]  psw_flags;
    logic        alu_carry_in;
    logic        wb_done;

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] model_psw;

    alu_writeback dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_wb_valid     (wb_valid),
        .o_wb_ready     (wb_ready),
        .i_wb_dst       (wb_dst),
        .i_wb_reg_en    (wb_reg_en),
        .i_wb_flag_mask (wb_flag_mask),
        .i_byte_op      (byte_op),
        .i_alu_result   (alu_result),
        .i_alu_carry    (alu_carry),
        .i_alu_zero     (alu_zero),
        .i_alu_neg      (alu_neg),
        .i_alu_ovf      (alu_ovf),
        .i_psw_load     (psw_load),
        .i_psw_in       (psw_in),
        .o_rf_wr_req    (rf_wr_req),
        .i_rf_wr_ack    (rf_wr_ack),
        .o_rf_wr_addr   (rf_wr_addr),
        .o_rf_wr_data   (rf_wr_data),
        .o_rf_wr_byte   (rf_wr_byte),
        .o_psw_flags    (psw_flags),
        .o_alu_carry_in (alu_carry_in),
        .o_wb_done      (wb_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] result;
        logic [3:0]  flags;     // {V,N,Z,C} from the ALU
        logic [3:0]  mask;
        logic        reg_en;
        logic [2:0]  dst;
        logic        byte_op;
        int          ack_delay; // cycles of req before ack is raised
        logic        load;
        logic [3:0]  load_val;
        logic [3:0]  exp_psw;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full command: handshake, optional write with delayed ack, done pulse
    task automatic run_cmd(input vec_t v);
        int waited = 0;
        while (!wb_ready && waited < 20) begin
            tick();
            waited++;
        end
        chk("ready_before_cmd", {31'd0, wb_ready}, 32'd1);
        wb_valid     = 1'b1;
        wb_dst       = v.dst;
        wb_reg_en    = v.reg_en;
        wb_flag_mask = v.mask;
        byte_op      = v.byte_op;
        alu_result   = v.result;
        {alu_ovf, alu_neg, alu_zero, alu_carry} = v.flags;
        psw_load     = v.load;
        psw_in       = v.load_val;
        rf_wr_ack    = 1'b0;
        tick();
        // Scramble the ALU side so a payload that is not held gets caught
        wb_valid   = 1'b0;
        psw_load   = 1'b0;
        alu_result = ~v.result;
        byte_op    = ~v.byte_op;
        wb_dst     = ~v.dst;
        chk("psw_after_hs", {28'd0, psw_flags}, {28'd0, v.exp_psw});
        chk("carry_in_after_hs", {31'd0, alu_carry_in}, {31'd0, v.exp_psw[0]});
        chk("ready_low_after_hs", {31'd0, wb_ready}, 32'd0);
        if (v.reg_en) begin
            for (int k = 0; k <= v.ack_delay; k++) begin
                chk("wr_req_held", {31'd0, rf_wr_req}, 32'd1);
                chk("wr_addr", {29'd0, rf_wr_addr}, {29'd0, v.dst});
                chk("wr_data", {16'd0, rf_wr_data}, {16'd0, v.result});
                chk("wr_byte", {31'd0, rf_wr_byte}, {31'd0, v.byte_op});
                chk("done_low_in_write", {31'd0, wb_done}, 32'd0);
                if (k == v.ack_delay) rf_wr_ack = 1'b1;
                tick();
            end
            rf_wr_ack = 1'b0;
        end
        chk("wr_req_low_at_done", {31'd0, rf_wr_req}, 32'd0);
        chk("done_pulse", {31'd0, wb_done}, 32'd1);
        chk("ready_low_at_done", {31'd0, wb_ready}, 32'd0);
        tick();
        chk("done_one_cycle", {31'd0, wb_done}, 32'd0);
        chk("ready_after_done", {31'd0, wb_ready}, 32'd1);
        chk("psw_stable", {28'd0, psw_flags}, {28'd0, v.exp_psw});
        model_psw = v.exp_psw;
    endtask

    vec_t tbl[4];

    initial begin
        logic [5:0] exp_rdy;
        logic [5:0] exp_req;
        logic [5:0] exp_done;
        vec_t v;

        rst_n = 1'b0; wb_valid = 1'b0; wb_dst = '0; wb_reg_en = 1'b0;
        wb_flag_mask = '0; byte_op = 1'b0; alu_result = '0;
        alu_carry = 1'b0; alu_zero = 1'b0; alu_neg = 1'b0; alu_ovf = 1'b0;
        psw_load = 1'b0; psw_in = '0; rf_wr_ack = 1'b0;
        model_psw = 4'b0000;

        //          result    {VNZC}   mask     reg  dst   byte ack load  ldval    exp_psw
        tbl[0] = '{16'h00FE, 4'b0000, 4'b1111, 1'b1, 3'd2, 1'b0, 0, 1'b0, 4'b0000, 4'b0000};
        tbl[1] = '{16'h0001, 4'b1001, 4'b1001, 1'b1, 3'd5, 1'b1, 3, 1'b0, 4'b0000, 4'b1001};
        tbl[2] = '{16'h0000, 4'b0011, 4'b1111, 1'b0, 3'd1, 1'b0, 0, 1'b0, 4'b0000, 4'b0011};
        tbl[3] = '{16'h1234, 4'b1000, 4'b1111, 1'b1, 3'd7, 1'b0, 1, 1'b1, 4'b0110, 4'b0110};

        tick();
        tick();
        chk("rst_ready", {31'd0, wb_ready}, 32'd1);
        chk("rst_psw", {28'd0, psw_flags}, 32'd0);
        chk("rst_carry_in", {31'd0, alu_carry_in}, 32'd0);
        chk("rst_req", {31'd0, rf_wr_req}, 32'd0);
        chk("rst_done", {31'd0, wb_done}, 32'd0);
        chk("rst_addr_data", {13'd0, rf_wr_addr, rf_wr_data}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) run_cmd(tbl[i]);

        // Random commands against the transaction-level PSW model
        for (int i = 0; i < 60; i++) begin
            v.result    = 16'($urandom);
            v.flags     = 4'($urandom);
            v.mask      = 4'($urandom);
            v.reg_en    = ($urandom_range(0, 3) != 0);
            v.dst       = 3'($urandom);
            v.byte_op   = 1'($urandom);
            v.ack_delay = $urandom_range(0, 3);
            v.load      = ($urandom_range(0, 7) == 0);
            v.load_val  = 4'($urandom);
            v.exp_psw   = v.load ? v.load_val
                                 : ((model_psw & ~v.mask) | (v.flags & v.mask));
            run_cmd(v);
        end

        // Reset during WRITE abandons the write and issues no done
        wb_valid = 1'b1; wb_reg_en = 1'b1; wb_dst = 3'd4; alu_result = 16'hBEEF;
        wb_flag_mask = 4'b1111; {alu_ovf, alu_neg, alu_zero, alu_carry} = 4'b1101;
        byte_op = 1'b1;
        tick();
        wb_valid = 1'b0;
        chk("pre_rst_req", {31'd0, rf_wr_req}, 32'd1);
        chk("pre_rst_psw", {28'd0, psw_flags}, 32'hD);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_req", {31'd0, rf_wr_req}, 32'd0);
        chk("mid_rst_psw", {28'd0, psw_flags}, 32'd0);
        chk("mid_rst_ready", {31'd0, wb_ready}, 32'd1);
        chk("mid_rst_done", {31'd0, wb_done}, 32'd0);
        chk("mid_rst_payload", {12'd0, rf_wr_byte, rf_wr_addr, rf_wr_data}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_done", {31'd0, wb_done}, 32'd0);
        chk("post_rst_ready", {31'd0, wb_ready}, 32'd1);
        model_psw = 4'b0000;

        // Back-to-back with valid and ack held high: ack outside WRITE ignored
        exp_rdy  = 6'b100100;
        exp_req  = 6'b010010;
        exp_done = 6'b001001;
        wb_valid = 1'b1; rf_wr_ack = 1'b1; wb_flag_mask = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            chk("b2b_ready", {31'd0, wb_ready}, {31'd0, exp_rdy[5-i]});
            chk("b2b_req", {31'd0, rf_wr_req}, {31'd0, exp_req[5-i]});
            chk("b2b_done", {31'd0, wb_done}, {31'd0, exp_done[5-i]});
            tick();
        end
        wb_valid = 1'b0; rf_wr_ack = 1'b0;
        chk("b2b_psw_unchanged", {28'd0, psw_flags}, {28'd0, model_psw});
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
